gray_rx: RTL and testbench

Receive-side decoder and checker for the free-running Gray-code counter stream produced by the counter block. It converts each incoming Gray word to binary and locks onto the +1 sequence. Once locked, it flags any skipped, repeated or corrupted word and emits the wrap marker `sig` when the decoded count is zero. It sits at the consumer end of the counter link and feeds the status/liveness logic.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_rx_if.sv | 24 ++
 rtl/gray_to_bin.sv | 13 +
 rtl/gray_rx.sv | 154 +++++++++++++++
 tb/tb_gray_rx.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray-code counter link.
package gray_pkg;

  // Widest count the helpers handle; narrower words are zero-extended into it.
  localparam int GMAX = 64;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Prefix XOR from the MSB down. Zero-extended upper bits leave the low bits unchanged.
  function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g);
    logic [GMAX-1:0] b;
    b[GMAX-1] = g[GMAX-1];
    for (int i = GMAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Standard reflected-binary encoding, kept here for a future transmitter.
  function automatic logic [GMAX-1:0] bin2gray(input logic [GMAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_rx_if.sv
// Stream-side signal bundle of the Gray-code receiver.
interface gray_rx_if #(
  parameter int CBITS = 18,
  parameter int ECW   = 8
);
  logic [CBITS-1:0] gray_in;
  logic             valid_in;
  logic [CBITS-1:0] bin_out;
  logic             bin_valid;
  logic             sig;
  logic             locked;
  logic             err;
  logic [ECW-1:0]   err_cnt;

  modport master (
    output gray_in, valid_in,
    input  bin_out, bin_valid, sig, locked, err, err_cnt
  );

  modport slave (
    input  gray_in, valid_in,
    output bin_out, bin_valid, sig, locked, err, err_cnt
  );
endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter of CBITS width (CBITS must not exceed GMAX).
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int CBITS = 18
) (
  input  logic [CBITS-1:0] gray,
  output logic [CBITS-1:0] bin
);

  assign bin = CBITS'(gray2bin(GMAX'(gray)));

endmodule

// File: rtl/gray_rx.sv
// Two-stage Gray-code receiver: capture, decode, and +1 sequence lock/loss tracking.
module gray_rx
  import gray_pkg::*;
#(
  parameter int CBITS    = 18,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ECW      = 8
) (
  input logic       clk,
  input logic       rst,
  gray_rx_if.slave  bus
);

  localparam int RUNW  = $clog2(LOCK_CNT + 1);
  localparam int MISSW = $clog2(LOSS_CNT + 1);
  localparam logic [RUNW-1:0]  RUN_LAST  = RUNW'(LOCK_CNT - 1);
  localparam logic [MISSW-1:0] MISS_LAST = MISSW'(LOSS_CNT - 1);

  // Stage 1
  logic [CBITS-1:0] gray_q, gray_d;
  logic             v_q, v_d;

  // Stage 2 outputs
  logic [CBITS-1:0] bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             sig_q, sig_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ECW-1:0]   err_cnt_q, err_cnt_d;

  // Sequence tracking
  logic [CBITS-1:0] last_q, last_d;
  logic             have_last_q, have_last_d;
  logic [RUNW-1:0]  run_q, run_d;
  logic [MISSW-1:0] miss_q, miss_d;
  state_t           state_q, state_d;

  logic [CBITS-1:0] bin_w;
  logic [CBITS-1:0] exp_next;
  logic             good;

  gray_to_bin #(.CBITS(CBITS)) u_g2b (
    .gray (gray_q),
    .bin  (bin_w)
  );

  // Next-state logic for both pipeline stages, the lock FSM and its counters.
  always_comb begin
    gray_d      = gray_q;
    v_d         = bus.valid_in;
    bin_out_d   = bin_out_q;
    bin_valid_d = v_q;
    sig_d       = v_q && (bin_w == '0);
    locked_d    = locked_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    run_d       = run_q;
    miss_d      = miss_q;
    state_d     = state_q;

    // Increment wraps modulo 2^CBITS, so all-ones followed by zero counts as good.
    exp_next = last_q + CBITS'(1);
    good     = have_last_q && (bin_w == exp_next);

    if (bus.valid_in) begin
      gray_d = bus.gray_in;
    end

    if (v_q) begin
      bin_out_d   = bin_w;
      last_d      = bin_w;
      have_last_d = 1'b1;
      case (state_q)
        SEARCH: begin
          if (have_last_q) begin
            if (good) begin
              run_d = run_q + RUNW'(1);
              if (run_q == RUN_LAST) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
                miss_d   = '0;
              end
            end else begin
              run_d = '0;
            end
          end
        end
        LOCKED: begin
          if (good) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ECW'(1);
            end
            if (miss_q == MISS_LAST) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              run_d    = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_q + MISSW'(1);
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // State registers; reset discards any words still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q      <= '0;
      v_q         <= 1'b0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      sig_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      run_q       <= '0;
      miss_q      <= '0;
      state_q     <= SEARCH;
    end else begin
      gray_q      <= gray_d;
      v_q         <= v_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      sig_q       <= sig_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      state_q     <= state_d;
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.sig       = sig_q;
  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_rx.sv
// Self-checking bench for gray_rx: directed scenarios plus a randomized stream vs a word-level model.
module tb_gray_rx;

  localparam int CB  = 4;
  localparam int LK  = 4;
  localparam int LS  = 2;
  localparam int EW  = 8;
  localparam int MOD = 1 << CB;
  localparam int SAT = (1 << EW) - 1;

  typedef struct packed {
    logic [CB-1:0] bout;
    logic          bv;
    logic          sig;
    logic          lk;
    logic          err;
    logic [EW-1:0] ec;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  gray_rx_if #(.CBITS(CB), .ECW(EW)) bus ();

  gray_rx #(.CBITS(CB), .LOCK_CNT(LK), .LOSS_CNT(LS), .ECW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Word-level reference: tracks only what the stream rules talk about.
  int m_last, m_run, m_miss, m_cnt, m_bout;
  bit m_have, m_lk;

  task automatic mdl_reset();
    m_last = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_bout = 0;
    m_have = 0; m_lk = 0;
  endtask

  task automatic mdl_word(input bit v, input int b, output out_t e);
    bit good;
    bit er;
    er = 0;
    if (v) begin
      good = m_have && (b == (m_last + 1) % MOD);
      if (!m_lk) begin
        if (m_have) begin
          if (good) begin
            m_run++;
            if (m_run == LK) begin m_lk = 1; m_miss = 0; end
          end else m_run = 0;
        end
      end else if (good) begin
        m_miss = 0;
      end else begin
        er = 1;
        if (m_cnt < SAT) m_cnt++;
        m_miss++;
        if (m_miss == LS) begin m_lk = 0; m_run = 0; end
      end
      m_last = b; m_have = 1; m_bout = b;
    end
    e = {CB'(m_bout), v, v && (b == 0), m_lk, er, EW'(m_cnt)};
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic step(input logic r, input logic v, input int b, output out_t obs);
    logic [CB-1:0] bb;
    bb = CB'(b);
    rst          = r;
    bus.valid_in = v;
    bus.gray_in  = bb ^ (bb >> 1);
    @(posedge clk);
    @(negedge clk);
    obs = {bus.bin_out, bus.bin_valid, bus.sig, bus.locked, bus.err, bus.err_cnt};
  endtask

  task automatic test_reset();
    out_t obs;
    step(1, 1, 3, obs);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_a got=%h want=%h", obs, out_t'(0)); end
    step(1, 0, 0, obs);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_b got=%h want=%h", obs, out_t'(0)); end
  endtask

  task automatic test_basic();
    out_t obs, exp;
    step(1, 0, 0, obs);
    for (int j = 0; j <= 6; j++) begin
      step(0, j < 6, (j < 6) ? j : 0, obs);
      if (j == 0) exp = '0;
      else exp = {CB'(j - 1), 1'b1, (j - 1) == 0, (j - 1) >= 4, 1'b0, EW'(0)};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL basic step=%0d got=%h want=%h", j, obs, exp); end
    end
  endtask

  // Continues from test_basic: locked, last decoded word 5, pipeline idle.
  task automatic test_wrap();
    out_t obs, exp;
    int   w;
    int   sig_seen;
    sig_seen = 0;
    for (int i = 0; i <= 12; i++) begin
      w = (6 + i) % MOD;
      step(0, i < 12, w, obs);
      if (i == 0) exp = {CB'(5), 1'b0, 1'b0, 1'b1, 1'b0, EW'(0)};
      else exp = {CB'((6 + i - 1) % MOD), 1'b1, ((6 + i - 1) % MOD) == 0, 1'b1, 1'b0, EW'(0)};
      if (obs.sig) sig_seen++;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL wrap step=%0d got=%h want=%h", i, obs, exp); end
    end
    total++;
    if (sig_seen != 1) begin bad++; $display("FAIL wrap_sig count got=%0d want=1", sig_seen); end
  endtask

  task automatic test_skip();
    int   w[9] = '{0, 1, 2, 3, 4, 5, 6, 8, 9};
    out_t obs, exp;
    step(1, 0, 0, obs);
    for (int i = 0; i <= 9; i++) begin
      step(0, i < 9, (i < 9) ? w[i] : 0, obs);
      if (i == 0) exp = '0;
      else exp = {CB'(w[i-1]), 1'b1, w[i-1] == 0, (i - 1) >= 4, w[i-1] == 8, EW'((i - 1) >= 7 ? 1 : 0)};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL skip step=%0d got=%h want=%h", i, obs, exp); end
    end
  endtask

  task automatic test_repeat();
    int   w[13]  = '{0, 1, 2, 3, 4, 5, 6, 6, 6, 7, 8, 9, 10};
    int   lk[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    int   er[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    int   ec[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2};
    out_t obs, exp;
    step(1, 0, 0, obs);
    for (int i = 0; i <= 13; i++) begin
      step(0, i < 13, (i < 13) ? w[i] : 0, obs);
      if (i == 0) exp = '0;
      else exp = {CB'(w[i-1]), 1'b1, w[i-1] == 0, lk[i-1] == 1, er[i-1] == 1, EW'(ec[i-1])};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL repeat step=%0d got=%h want=%h", i, obs, exp); end
    end
  endtask

  task automatic test_gaps();
    int   v[6] = '{1, 0, 0, 1, 0, 1};
    int   w[6] = '{0, 0, 0, 1, 0, 2};
    int   held;
    out_t obs, exp;
    held = 0;
    step(1, 0, 0, obs);
    for (int i = 0; i <= 6; i++) begin
      step(0, (i < 6) && (v[i] == 1), (i < 6) ? w[i] : 0, obs);
      if (i == 0) exp = '0;
      else begin
        if (v[i-1] == 1) held = w[i-1];
        exp = {CB'(held), v[i-1] == 1, (v[i-1] == 1) && (w[i-1] == 0), 1'b0, 1'b0, EW'(0)};
      end
      total++;
      if (obs !== exp) begin bad++; $display("FAIL gaps step=%0d got=%h want=%h", i, obs, exp); end
    end
  endtask

  task automatic test_midreset();
    int   w[9] = '{0, 1, 2, 3, 4, 5, 9, 10, 11};
    out_t obs, exp;
    step(1, 0, 0, obs);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, w[i], obs);
      if (i == 7) begin
        exp = {CB'(9), 1'b1, 1'b0, 1'b1, 1'b1, EW'(1)};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_pre9 got=%h want=%h", obs, exp); end
      end
      if (i == 8) begin
        exp = {CB'(10), 1'b1, 1'b0, 1'b1, 1'b0, EW'(1)};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_pre10 got=%h want=%h", obs, exp); end
      end
    end
    step(1, 1, 12, obs);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== '0) begin bad++; $display("FAIL midrst_post%0d got=%h want=%h", i, obs, out_t'(0)); end
      if (i < 2) step(0, 0, 0, obs);
    end
  endtask

  task automatic test_random();
    out_t q[$];
    out_t obs, e;
    int   drv, b, k;
    bit   r, v;
    drv = 0;
    mdl_reset();
    step(1, 0, 0, obs);
    q.delete();
    q.push_back('0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(199) == 0);
      v = ($urandom_range(3) != 0);
      k = $urandom_range(9);
      if (k < 7) b = (drv + 1) % MOD;
      else if (k == 7) b = drv;
      else b = $urandom_range(MOD - 1);
      if (r) begin
        step(1, v, b, obs);
        mdl_reset();
        q.delete();
        q.push_back('0);
        e = '0;
      end else begin
        mdl_word(v, b, e);
        q.push_back(e);
        step(0, v, b, obs);
        e = q.pop_front();
        if (v) drv = b;
      end
      total++;
      if (obs !== e) begin bad++; $display("FAIL random i=%0d got=%h want=%h", i, obs, e); end
    end
  endtask

  task automatic test_saturate();
    out_t q[$];
    out_t obs, e;
    int   w, n, errs;
    errs = 0;
    mdl_reset();
    step(1, 0, 0, obs);
    q.delete();
    q.push_back('0);
    n = 5 + 2 * 270;
    for (int i = 0; i <= n; i++) begin
      // Lock on 0..4, then alternate a good increment with a repeat of it.
      if (i < 5) w = i;
      else w = (5 + (i - 5) / 2) % MOD;
      mdl_word(i < n, w, e);
      q.push_back(e);
      step(0, i < n, w, obs);
      e = q.pop_front();
      if (obs.err) errs++;
      total++;
      if (obs !== e) begin bad++; $display("FAIL sat i=%0d got=%h want=%h", i, obs, e); end
    end
    total++;
    if (errs != 270) begin bad++; $display("FAIL sat_pulses got=%0d want=270", errs); end
    total++;
    if (obs.ec !== EW'(SAT)) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", obs.ec, SAT); end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.gray_in  = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_skip();
    test_repeat();
    test_gaps();
    test_midreset();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
